// File: rtl/vec_uop_sequencer.sv
// RVV vtype/vl configuration holder and LMUL-group micro-op expander.
// Sits between vector decode and the single-register execution datapath.
module vec_uop_sequencer #(
  parameter int VLEN = 128,
  parameter int VL_W = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [2:0]      cfg_sew_enc,
  input  logic [2:0]      cfg_lmul_enc,
  input  logic [31:0]     cfg_avl,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [4:0]      op_vd,
  input  logic [4:0]      op_vs2,
  input  logic [4:0]      op_vs1,
  output logic            op_err,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic [4:0]      uop_vd,
  output logic [4:0]      uop_vs2,
  output logic [4:0]      uop_vs1,
  output logic [2:0]      uop_idx,
  output logic [VL_W-1:0] uop_elems,
  output logic            uop_last,
  output logic [VL_W-1:0] vl,
  output logic [6:0]      vsew,
  output logic [3:0]      vlmul,
  output logic            vill
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic [VL_W-1:0] VLEN_V = VL_W'(VLEN);

  logic [0:0]      state_q, state_d;
  logic            vill_q, vill_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [6:0]      vsew_q, vsew_d;
  logic [3:0]      vlmul_q, vlmul_d;
  logic [VL_W-1:0] epr_q, epr_d;
  logic [4:0]      vd_q, vd_d;
  logic [4:0]      vs2_q, vs2_d;
  logic [4:0]      vs1_q, vs1_d;
  logic [2:0]      idx_q, idx_d;
  logic [VL_W-1:0] rem_q, rem_d;
  logic            op_err_q, op_err_d;

  logic            idle;
  logic            issuing;
  logic            cfg_fire;
  logic            op_fire;
  logic            uop_fire;
  logic            cfg_legal;
  logic [VL_W-1:0] cfg_epr;
  logic [VL_W-1:0] cfg_vlmax;
  logic [VL_W-1:0] cfg_vl;
  logic [4:0]      lmul_mask;
  logic            misaligned;
  logic            cur_last;

  assign idle     = (state_q == ST_IDLE);
  assign issuing  = (state_q == ST_ISSUE);
  assign cfg_fire = cfg_valid && idle;
  assign op_fire  = op_valid && idle && !cfg_valid;
  assign uop_fire = issuing && uop_ready;
  assign cur_last = (rem_q <= epr_q);

  // Config decode: EPR = VLEN/SEW, VLMAX = EPR*LMUL, avl clipped at full 32-bit width.
  always_comb begin
    cfg_legal = !cfg_sew_enc[2] && !cfg_lmul_enc[2];
    cfg_epr   = VLEN_V >> (3'd3 + {1'b0, cfg_sew_enc[1:0]});
    cfg_vlmax = cfg_epr << cfg_lmul_enc[1:0];
    if (cfg_avl < 32'(cfg_vlmax)) begin
      cfg_vl = cfg_avl[VL_W-1:0];
    end else begin
      cfg_vl = cfg_vlmax;
    end
  end

  // A group base must be a multiple of LMUL; vlmul is a power of two so LMUL-1 is a mask.
  always_comb begin
    lmul_mask  = {1'b0, vlmul_q - 4'd1};
    misaligned = |(op_vd & lmul_mask) || |(op_vs2 & lmul_mask) || |(op_vs1 & lmul_mask);
  end

  always_comb begin
    state_d  = state_q;
    vill_d   = vill_q;
    vl_d     = vl_q;
    vsew_d   = vsew_q;
    vlmul_d  = vlmul_q;
    epr_d    = epr_q;
    vd_d     = vd_q;
    vs2_d    = vs2_q;
    vs1_d    = vs1_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    op_err_d = 1'b0;

    if (cfg_fire) begin
      if (cfg_legal) begin
        vill_d  = 1'b0;
        vl_d    = cfg_vl;
        vsew_d  = 7'd8 << cfg_sew_enc[1:0];
        vlmul_d = 4'd1 << cfg_lmul_enc[1:0];
        epr_d   = cfg_epr;
      end else begin
        vill_d  = 1'b1;
        vl_d    = '0;
        vsew_d  = '0;
        vlmul_d = '0;
        epr_d   = '0;
      end
    end else if (op_fire) begin
      // Ops under an illegal or empty config are swallowed silently.
      if (!vill_q && (vl_q != '0)) begin
        if (misaligned) begin
          op_err_d = 1'b1;
        end else begin
          vd_d    = op_vd;
          vs2_d   = op_vs2;
          vs1_d   = op_vs1;
          idx_d   = 3'd0;
          rem_d   = vl_q;
          state_d = ST_ISSUE;
        end
      end
    end

    if (uop_fire) begin
      idx_d = idx_q + 3'd1;
      rem_d = rem_q - epr_q;
      if (cur_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vill_q   <= 1'b1;
      vl_q     <= '0;
      vsew_q   <= '0;
      vlmul_q  <= '0;
      epr_q    <= '0;
      vd_q     <= '0;
      vs2_q    <= '0;
      vs1_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vill_q   <= vill_d;
      vl_q     <= vl_d;
      vsew_q   <= vsew_d;
      vlmul_q  <= vlmul_d;
      epr_q    <= epr_d;
      vd_q     <= vd_d;
      vs2_q    <= vs2_d;
      vs1_q    <= vs1_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      op_err_q <= op_err_d;
    end
  end

  // Micro-op fields are forced to zero outside ISSUE so idle outputs stay clean.
  always_comb begin
    uop_valid = issuing;
    uop_vd    = '0;
    uop_vs2   = '0;
    uop_vs1   = '0;
    uop_idx   = '0;
    uop_elems = '0;
    uop_last  = 1'b0;
    if (issuing) begin
      uop_vd    = vd_q + {2'b00, idx_q};
      uop_vs2   = vs2_q + {2'b00, idx_q};
      uop_vs1   = vs1_q + {2'b00, idx_q};
      uop_idx   = idx_q;
      uop_elems = cur_last ? rem_q : epr_q;
      uop_last  = cur_last;
    end
  end

  assign cfg_ready = idle;
  assign op_ready  = idle && !cfg_valid;
  assign op_err    = op_err_q;
  assign vl        = vl_q;
  assign vsew      = vsew_q;
  assign vlmul     = vlmul_q;
  assign vill      = vill_q;

endmodule
